yuv422_fb_reader: RTL
=====================

// Module: yuv422_fb_reader
// PURPOSE
// - Downstream consumer of the yuv422 framebuffer BRAM. Scans the buffer in raster order, driven
//   by the video timing generator (de/hsync/vsync).
// - Drives the BRAM read address and unpacks each 32-bit word (2 pixels, 4:2:2) into one Y/C pair
//   per clock for the HDMI encoder.
// - Optional 2^SCALE_SHIFT pixel/line replication. Pixels outside the buffer area are black.
// PARAMETERS
// - FB_W         64           framebuffer width in pixels; even; FB_W/2 words per row
// - FB_H         48           framebuffer height in lines
// - SCALE_SHIFT  0            upscale factor = 2^SCALE_SHIFT in both axes
// - CNT_W        12           display x/y counter width; counters saturate at all-ones
// - VS_POL       1'b1         active level of vsync_i
// - LINES        FB_W*FB_H/2  BRAM depth; address width = $clog2(LINES)
// PORTS
// - clk_i      in   1                 pixel clock
// - rst_ni     in   1                 reset, synchronous, active-low
// - de_i       in   1                 display enable from timing gen
// - hsync_i    in   1                 hsync from timing gen, passed through
// - vsync_i    in   1                 vsync from timing gen
// - rd_addr_o  out  $clog2(LINES)     BRAM read address, registered
// - rd_d_i     in   32                BRAM read data; combinational read of rd_addr_o, same cycle
// - y_o        out  8                 luma
// - c_o        out  8                 chroma: Cb on even source pixels, Cr on odd
// - de_o       out  1                 de_i delayed by 2
// - hsync_o    out  1                 hsync_i delayed by 2
// - vsync_o    out  1                 vsync_i delayed by 2
// BEHAVIOUR
// - Word layout:
//   - [7:0]=Y0, [15:8]=Cb, [23:16]=Y1, [31:24]=Cr.
//   - Even source x uses Y0/Cb; odd source x uses Y1/Cr.
// - Latency is fixed at 2 cycles from the timing inputs to all outputs.
//   - Cycle n: de_i is sampled.
//   - Cycle n+1: rd_addr_o is updated.
//   - Cycle n+2: y_o/c_o are registered and aligned with de_o.
// - Reset (rst_ni=0 at a clk edge):
//   - rd_addr_o=0, y_o=0, c_o=0, de_o/hsync_o/vsync_o=0.
//   - Delay pipes are cleared, counters are 0, state goes to WAIT_VS.
// - FSM WAIT_VS:
//   - Outputs black (y=0x10, c=0x80) wherever the delayed de is 1.
//   - Timing signals are still passed through.
//   - Moves to ACTIVE on a vsync_i leading edge (transition to VS_POL).
// - FSM ACTIVE:
//   - A vsync_i leading edge clears dx, dy, row base and rd_addr_o (stays in ACTIVE).
//   - Reset mid-frame therefore blanks the picture until the next frame.
// - Counters:
//   - dx increments on each de_i=1 cycle and clears on the de_i falling edge.
//   - dy increments on the de_i falling edge.
//   - Source coordinates: sx = dx>>SCALE_SHIFT, sy = dy>>SCALE_SHIFT.
// - Address generation (no multiplier):
//   - A row-base register adds FB_W/2 when sy advances and sy < FB_H.
//   - rd_addr_o = row_base + (sx>>1).
// - In-area test: sx < FB_W and sy < FB_H.
//   - Out-of-area pixels output black.
//   - rd_addr_o holds its last value; it never exceeds LINES-1.
// - Simultaneous de_i fall and vsync edge in one cycle: vsync wins, dy=0 (not 1).
// - de_i held with no vsync: dx/dy saturate and do not wrap; output is black once out of area.
// - de_o=0: y_o/c_o are driven to black values, not held.
// STRUCTURE
// - Package yuv422_fb_pkg:
//   - typedef struct packed {cr, y1, cb, y0} yuv422_word_t.
//   - Constants BLACK_Y=8'h10, BLACK_C=8'h80.
//   - Shared with the framebuffer writer.
// - Sub-module yuv422_fb_addr_gen: counters, edge detects, row base, in-area flag, rd_addr_o.
// - Top level: FSM, 2-stage timing delay, unpack mux.
// TESTING
// - Reset: rst_ni=0 with toggling timing -> all outputs 0; after release, black until first vsync.
// - Raster, FB_W=4, FB_H=2, S=0, mem = {0x80_11_40_10, 0x81_13_41_12, 0x82_15_42_14, 0x83_17_43_16}:
//   - Line 0 (de=1 for 4 clk) -> y_o = 10,11,12,13 and c_o = 40,80,41,81 (hex), on cycles 2..5
//     after de_i rises.
//   - Line 1 -> y_o = 14..17.
// - Scale S=1, same mem:
//   - Line 0 -> y_o = 10,10,11,11,12,12,13,13 over 8 clk.
//   - Display lines 0 and 1 are identical; line 2 reads row 1.
// - Out-of-area: de_i=1 for 10 clk with FB_W=4, S=0 -> pixels 4..9 give y=10, c=80 (black);
//   rd_addr_o stays at 1.
// - Mid-frame vsync edge coinciding with a de_i falling edge -> next line reads row 0, addr 0.
// - Mid-frame reset then vsync -> black until vsync; the following frame matches the raster-test
//   values exactly.

Source files
------------

// File: rtl/yuv422_fb_pkg.sv
// Shared definitions for the yuv422 framebuffer writer and reader.
// Word layout, black levels and reader FSM states.
package yuv422_fb_pkg;

   typedef struct packed {
      logic [7:0] cr;
      logic [7:0] y1;
      logic [7:0] cb;
      logic [7:0] y0;
   } yuv422_word_t;

   localparam logic [7:0] BLACK_Y = 8'h10;
   localparam logic [7:0] BLACK_C = 8'h80;

   typedef enum logic {
      WAIT_VS,
      ACTIVE
   } rd_state_e;

endpackage

// File: rtl/yuv422_fb_addr_gen.sv
// Raster counters and BRAM address generation for the yuv422 reader.
// Row base is accumulated so no multiplier is needed.
module yuv422_fb_addr_gen #(
   parameter int         FB_W        = 64,
   parameter int         FB_H        = 48,
   parameter int         SCALE_SHIFT = 0,
   parameter int         CNT_W       = 12,
   parameter logic       VS_POL      = 1'b1,
   parameter int         LINES       = FB_W * FB_H / 2,
   localparam int        AW          = $clog2(LINES)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          de_i,
   input  logic          vsync_i,
   output logic [AW-1:0] rd_addr_o,
   output logic          in_area_o,
   output logic          odd_o,
   output logic          vs_edge_o
);

   localparam logic [CNT_W-1:0] FB_W_C = CNT_W'(FB_W);
   localparam logic [CNT_W-1:0] FB_H_C = CNT_W'(FB_H);
   localparam logic [AW-1:0]    ROW_W  = AW'(FB_W / 2);

   logic             de_q;
   logic             vs_q;
   logic [CNT_W-1:0] dx;
   logic [CNT_W-1:0] dy;
   logic [CNT_W-1:0] dx_inc;
   logic [CNT_W-1:0] dy_inc;
   logic [CNT_W-1:0] sx;
   logic [CNT_W-1:0] sy;
   logic [CNT_W-1:0] sy_inc;
   logic [AW-1:0]    row_base;
   logic             de_fall;
   logic             row_adv;

   assign vs_edge_o = (vsync_i == VS_POL) && (vs_q != VS_POL);
   assign de_fall   = de_q && !de_i;
   assign dx_inc    = (dx == '1) ? dx : dx + 1'b1;
   assign dy_inc    = (dy == '1) ? dy : dy + 1'b1;
   assign sx        = dx >> SCALE_SHIFT;
   assign sy        = dy >> SCALE_SHIFT;
   assign sy_inc    = dy_inc >> SCALE_SHIFT;
   assign row_adv   = (sy_inc != sy) && (sy_inc < FB_H_C);
   assign in_area_o = (sx < FB_W_C) && (sy < FB_H_C);
   assign odd_o     = sx[0];

   // Edge detect, saturating counters, row base and read address.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         de_q      <= 1'b0;
         vs_q      <= VS_POL;
         dx        <= '0;
         dy        <= '0;
         row_base  <= '0;
         rd_addr_o <= '0;
      end else begin
         de_q <= de_i;
         vs_q <= vsync_i;
         if (vs_edge_o) begin
            dx        <= '0;
            dy        <= '0;
            row_base  <= '0;
            rd_addr_o <= '0;
         end else begin
            if (de_i && in_area_o)
               rd_addr_o <= row_base + AW'(sx >> 1);
            if (de_fall) begin
               dx <= '0;
               dy <= dy_inc;
               if (row_adv)
                  row_base <= row_base + ROW_W;
            end else if (de_i) begin
               dx <= dx_inc;
            end
         end
      end
   end

endmodule

// File: rtl/yuv422_fb_reader.sv
// Raster reader for the yuv422 framebuffer feeding the HDMI encoder.
// Two-cycle pipeline: address, then unpacked Y/C pair.
module yuv422_fb_reader
   import yuv422_fb_pkg::*;
#(
   parameter int         FB_W        = 64,
   parameter int         FB_H        = 48,
   parameter int         SCALE_SHIFT = 0,
   parameter int         CNT_W       = 12,
   parameter logic       VS_POL      = 1'b1,
   parameter int         LINES       = FB_W * FB_H / 2,
   localparam int        AW          = $clog2(LINES)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          de_i,
   input  logic          hsync_i,
   input  logic          vsync_i,
   output logic [AW-1:0] rd_addr_o,
   input  logic [31:0]   rd_d_i,
   output logic [7:0]    y_o,
   output logic [7:0]    c_o,
   output logic          de_o,
   output logic          hsync_o,
   output logic          vsync_o
);

   rd_state_e    state;
   yuv422_word_t w;
   logic         in_area;
   logic         odd;
   logic         vs_edge;
   logic         de_d1;
   logic         hs_d1;
   logic         vs_d1;
   logic         ok_d1;
   logic         odd_d1;

   assign w = rd_d_i;

   yuv422_fb_addr_gen #(
      .FB_W        (FB_W),
      .FB_H        (FB_H),
      .SCALE_SHIFT (SCALE_SHIFT),
      .CNT_W       (CNT_W),
      .VS_POL      (VS_POL),
      .LINES       (LINES)
   ) u_addr (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .de_i      (de_i),
      .vsync_i   (vsync_i),
      .rd_addr_o (rd_addr_o),
      .in_area_o (in_area),
      .odd_o     (odd),
      .vs_edge_o (vs_edge)
   );

   // Picture is blanked until the first vsync leading edge.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state <= WAIT_VS;
      end else begin
         unique case (state)
            WAIT_VS: if (vs_edge) state <= ACTIVE;
            ACTIVE:  state <= ACTIVE;
            default: state <= WAIT_VS;
         endcase
      end
   end

   // Stage 1: delay timing and qualify the pixel alongside the address.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         de_d1  <= 1'b0;
         hs_d1  <= 1'b0;
         vs_d1  <= 1'b0;
         ok_d1  <= 1'b0;
         odd_d1 <= 1'b0;
      end else begin
         de_d1  <= de_i;
         hs_d1  <= hsync_i;
         vs_d1  <= vsync_i;
         ok_d1  <= de_i && in_area && (state == ACTIVE);
         odd_d1 <= odd;
      end
   end

   // Stage 2: unpack the BRAM word or emit black.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         de_o    <= 1'b0;
         hsync_o <= 1'b0;
         vsync_o <= 1'b0;
         y_o     <= '0;
         c_o     <= '0;
      end else begin
         de_o    <= de_d1;
         hsync_o <= hs_d1;
         vsync_o <= vs_d1;
         if (de_d1 && ok_d1) begin
            y_o <= odd_d1 ? w.y1 : w.y0;
            c_o <= odd_d1 ? w.cr : w.cb;
         end else begin
            y_o <= BLACK_Y;
            c_o <= BLACK_C;
         end
      end
   end

endmodule
